// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
// Counter encodings and default geometry.
package branch_predictor_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int INDEX_BITS = 8;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
// force_strong jumps straight to strong-taken (unconditional jumps).
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    input  logic       force_strong,
    output logic [1:0] next
);

    always_comb begin
        next = ctr;
        if (force_strong) begin
            next = CTR_ST;
        end else if (taken) begin
            next = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            next = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage BTB with optional 2-bit direction counters.
// Counters are enabled by defining BP_SAT_COUNTER_EN.
module branch_predictor #(
    parameter int WORD_SIZE  = branch_predictor_pkg::WORD_SIZE,
    parameter int INDEX_BITS = branch_predictor_pkg::INDEX_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] PC,
    output logic [WORD_SIZE-1:0] predicted_nextPC,
    output logic                 pred_hit,
    input  logic                 update_en,
    input  logic                 stall,
    input  logic [WORD_SIZE-1:0] update_PC,
    input  logic                 update_taken,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_unconditional
);

    import branch_predictor_pkg::*;

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    // Register array so every valid bit can be cleared asynchronously.
    logic [ENTRIES-1:0]   valid;
    logic [TAG_BITS-1:0]  tags    [ENTRIES];
    logic [WORD_SIZE-1:0] targets [ENTRIES];

    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] uidx;
    logic [TAG_BITS-1:0]   utag;
    logic                  uhit;
    logic                  commit;
    logic                  wr_en;
    logic                  inv_en;
    logic                  take;

    assign idx    = PC[INDEX_BITS-1:0];
    assign uidx   = update_PC[INDEX_BITS-1:0];
    assign utag   = update_PC[WORD_SIZE-1:INDEX_BITS];
    assign commit = update_en & ~stall;
    assign wr_en  = commit & update_taken;

    assign pred_hit = valid[idx] &&
                      (tags[idx] == PC[WORD_SIZE-1:INDEX_BITS]);
    assign uhit     = valid[uidx] && (tags[uidx] == utag);

`ifdef BP_SAT_COUNTER_EN
    logic [1:0] ctrs [ENTRIES];
    logic [1:0] ctr_cur;
    logic [1:0] ctr_next;
    logic       ctr_wr;

    // A fresh allocation behaves as weak-not-taken stepped once.
    assign ctr_cur = uhit ? ctrs[uidx] : CTR_WNT;
    assign ctr_wr  = commit & (update_taken | uhit);
    assign inv_en  = 1'b0;
    assign take    = pred_hit & ctrs[idx][1];

    sat_counter2 u_ctr (
        .ctr          (ctr_cur),
        .taken        (update_taken),
        .force_strong (update_unconditional),
        .next         (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (ctr_wr) begin
            ctrs[uidx] <= ctr_next;
        end
    end
`else
    logic unused_unconditional;

    assign unused_unconditional = update_unconditional;
    assign inv_en = commit & ~update_taken & uhit;
    assign take   = pred_hit;
`endif

    assign predicted_nextPC = take ? targets[idx]
                                   : PC + WORD_SIZE'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[uidx] <= 1'b1;
        end else if (inv_en) begin
            valid[uidx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[uidx]    <= utag;
            targets[uidx] <= update_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; expectations track
// whether BP_SAT_COUNTER_EN is defined.
module tb_branch_predictor;

    logic        clk;
    logic        reset_n;
    logic [15:0] PC;
    logic [15:0] predicted_nextPC;
    logic        pred_hit;
    logic        update_en;
    logic        stall;
    logic [15:0] update_PC;
    logic        update_taken;
    logic [15:0] update_target;
    logic        update_unconditional;

    int total;
    int fails;

`ifdef BP_SAT_COUNTER_EN
    localparam bit CTR = 1'b1;
`else
    localparam bit CTR = 1'b0;
`endif

    branch_predictor dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .PC                   (PC),
        .predicted_nextPC     (predicted_nextPC),
        .pred_hit             (pred_hit),
        .update_en            (update_en),
        .stall                (stall),
        .update_PC            (update_PC),
        .update_taken         (update_taken),
        .update_target        (update_target),
        .update_unconditional (update_unconditional)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] pc,
                       input logic h, input logic [15:0] n);
        PC = pc;
        #1;
        total++;
        assert ({pred_hit, predicted_nextPC} === {h, n})
        else begin
            fails++;
            $error("FAIL %s: got hit=%b npc=%h, expected hit=%b npc=%h",
                   name, pred_hit, predicted_nextPC, h, n);
        end
    endtask

    // Called just after a falling edge; commits on the next rising edge.
    task automatic upd(input logic [15:0] a, input logic t,
                       input logic [15:0] tg, input logic u);
        update_en            = 1'b1;
        update_PC            = a;
        update_taken         = t;
        update_target        = tg;
        update_unconditional = u;
        @(posedge clk);
        @(negedge clk);
        update_en = 1'b0;
    endtask

    initial begin
        total = 0;
        fails = 0;
        reset_n = 1'b0;
        stall = 1'b0;
        update_en = 1'b0;
        update_PC = '0;
        update_taken = 1'b0;
        update_target = '0;
        update_unconditional = 1'b0;
        PC = 16'h0010;

        // Reset, with an update attempted while reset is held
        #2;
        chk("reset_held", 16'h0010, 1'b0, 16'h0011);
        update_en = 1'b1;
        update_PC = 16'h0010;
        update_taken = 1'b1;
        update_target = 16'h0077;
        repeat (2) @(posedge clk);
        @(negedge clk);
        update_en = 1'b0;
        reset_n = 1'b1;
        chk("reset_release", 16'h0010, 1'b0, 16'h0011);

        // Allocate a conditional branch
        upd(16'h0020, 1'b1, 16'h0040, 1'b0);
        chk("alloc", 16'h0020, 1'b1, 16'h0040);

        // Hysteresis
        upd(16'h0020, 1'b0, 16'h0000, 1'b0);
        chk("hyst_nt", 16'h0020, CTR, 16'h0021);
        upd(16'h0020, 1'b1, 16'h0040, 1'b0);
        chk("hyst_t", 16'h0020, 1'b1, 16'h0040);

        // Not-taken miss never allocates
        upd(16'h0040, 1'b0, 16'h0099, 1'b0);
        chk("nt_miss", 16'h0040, 1'b0, 16'h0041);

        // Stall gating: entry at weak-not-taken, then a stalled taken update
        upd(16'h0030, 1'b1, 16'h0050, 1'b0);
        upd(16'h0030, 1'b0, 16'h0000, 1'b0);
        update_en = 1'b1;
        stall = 1'b1;
        update_PC = 16'h0030;
        update_taken = 1'b1;
        update_target = 16'h0050;
        update_unconditional = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_held", 16'h0030, CTR, 16'h0031);
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        update_en = 1'b0;
        chk("stall_commit", 16'h0030, 1'b1, 16'h0050);
        upd(16'h0030, 1'b0, 16'h0000, 1'b0);
        chk("stall_once", 16'h0030, CTR, 16'h0031);

        // Conflict replacement with same-cycle lookup of the old entry
        update_en = 1'b1;
        update_PC = 16'h0120;
        update_taken = 1'b1;
        update_target = 16'h0200;
        update_unconditional = 1'b0;
        chk("bypass_old", 16'h0020, 1'b1, 16'h0040);
        @(posedge clk);
        @(negedge clk);
        update_en = 1'b0;
        chk("conflict_evict", 16'h0020, 1'b0, 16'h0021);
        chk("conflict_new", 16'h0120, 1'b1, 16'h0200);

        // Wrap on a miss
        chk("wrap", 16'hFFFF, 1'b0, 16'h0000);

        // Unconditional jump goes straight to strong-taken
        upd(16'h0005, 1'b1, 16'h0100, 1'b1);
        chk("jal", 16'h0005, 1'b1, 16'h0100);
        upd(16'h0005, 1'b0, 16'h0000, 1'b0);
        chk("jal_nt1", 16'h0005, CTR, CTR ? 16'h0100 : 16'h0006);
        upd(16'h0005, 1'b0, 16'h0000, 1'b0);
        chk("jal_nt2", 16'h0005, CTR, 16'h0006);

        // Reset in the middle of an update cycle
        update_en = 1'b1;
        update_PC = 16'h0060;
        update_taken = 1'b1;
        update_target = 16'h0070;
        #2;
        reset_n = 1'b0;
        chk("reset_mid", 16'h0120, 1'b0, 16'h0121);
        @(posedge clk);
        @(negedge clk);
        update_en = 1'b0;
        reset_n = 1'b1;
        chk("reset_mid_upd", 16'h0060, 1'b0, 16'h0061);
        chk("reset_mid_old", 16'h0120, 1'b0, 16'h0121);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
